// File: rtl/prbs_checker_if.sv
// prbs_checker_if: received pattern stream in, lock/error status out.
// The master modport belongs to the link side, the slave modport to the checker.
interface prbs_checker_if #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             clear_cnt;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic             lockup;

    modport master (
        output in_valid, in_data, clear_cnt,
        input  locked, err_pulse, err_count, lockup
    );

    modport slave (
        input  in_valid, in_data, clear_cnt,
        output locked, err_pulse, err_count, lockup
    );
endinterface

// File: rtl/prbs_checker.sv
// prbs_checker: receiver-side checker for the XNOR-feedback LFSR pattern stream.
// It re-seeds from the incoming words while searching and declares lock after
// LOCK_CNT consecutive correct predictions. Once locked it flywheels on its own
// prediction and counts word errors. LOSS_CNT consecutive misses drop the lock.
// Optional all-ones lockup detection: define PRBS_CHECKER_LOCKUP_DET_EN.
module prbs_checker #(
    parameter int unsigned WIDTH    = 5,
    parameter int unsigned TAP_A    = 1,
    parameter int unsigned TAP_B    = 3,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic          clk,
    input  logic          rst,
    prbs_checker_if.slave bus
);
    // Run counters only have to hold 0 .. N-1; hitting N-1 on a qualifying
    // word is the transition point.
    localparam int unsigned MR_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
    localparam int unsigned MS_W = (LOSS_CNT > 1) ? $clog2(LOSS_CNT) : 1;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic             have_prev;
    logic [MR_W-1:0]  match_run;
    logic [MS_W-1:0]  miss_run;
    logic             locked_q;
    logic             err_pulse_q;
    logic [CNT_W-1:0] err_count_q;
    logic [WIDTH-1:0] expected_c;
    logic             match_c;
    logic             count_ok_c;

    // Next word predicted from the previous one (XNOR feedback).
    assign expected_c = {prev[WIDTH-2:0], ~(prev[TAP_A] ^ prev[TAP_B])};
    assign match_c    = (bus.in_data == expected_c);

`ifdef PRBS_CHECKER_LOCKUP_DET_EN
    logic lockup_q;

    // Flags the all-ones stuck state; cleared by the next valid non-all-ones word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lockup_q <= 1'b0;
        end else if (bus.in_valid) begin
            lockup_q <= (bus.in_data == '1);
        end
    end

    // A stuck stream predicts itself, so its matches must not build lock.
    assign count_ok_c = ~lockup_q;
    assign bus.lockup = lockup_q;
`else
    assign count_ok_c = 1'b1;
    assign bus.lockup = 1'b0;
`endif

    // Lock FSM, run counters, prediction register and error counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SEARCH;
            prev        <= '0;
            have_prev   <= 1'b0;
            match_run   <= '0;
            miss_run    <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_pulse_q <= 1'b0;
            if (bus.in_valid) begin
                case (state)
                    SEARCH: begin
                        prev <= bus.in_data;
                        if (!have_prev) begin
                            have_prev <= 1'b1;
                        end else if (match_c) begin
                            if (count_ok_c) begin
                                if (match_run == MR_W'(LOCK_CNT - 1)) begin
                                    state     <= LOCKED;
                                    locked_q  <= 1'b1;
                                    match_run <= '0;
                                    miss_run  <= '0;
                                end else begin
                                    match_run <= MR_W'(match_run + 1'b1);
                                end
                            end
                        end else begin
                            match_run <= '0;
                        end
                    end
                    LOCKED: begin
                        prev <= expected_c;
                        if (match_c) begin
                            miss_run <= '0;
                        end else begin
                            err_pulse_q <= 1'b1;
                            if (err_count_q != '1) begin
                                err_count_q <= CNT_W'(err_count_q + 1'b1);
                            end
                            if (miss_run == MS_W'(LOSS_CNT - 1)) begin
                                state     <= SEARCH;
                                locked_q  <= 1'b0;
                                have_prev <= 1'b0;
                                match_run <= '0;
                                miss_run  <= '0;
                            end else begin
                                miss_run <= MS_W'(miss_run + 1'b1);
                            end
                        end
                    end
                    default: begin
                        state <= SEARCH;
                    end
                endcase
            end
            // Clear takes priority over an error counted in the same cycle.
            if (bus.clear_cnt) begin
                err_count_q <= '0;
            end
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_count = err_count_q;
endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receiver-side checker for the 5-bit XNOR-feedback LFSR pattern stream produced by the team's pattern generator.
- Sits directly downstream of the generator, on the link or loopback under test.
- Self-synchronises from the incoming words, declares lock after a run of correct predictions, then flywheels and counts word errors until lock is lost.
- Outputs feed status registers and BER measurement logic.

Parameters:
- WIDTH, 5: LFSR word width.
- TAP_A, 1: first feedback tap bit index.
- TAP_B, 3: second feedback tap bit index.
- LOCK_CNT, 4: consecutive matches required to declare lock (>=1).
- LOSS_CNT, 3: consecutive mismatches while locked that drop lock (>=1).
- CNT_W, 16: error counter width.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: asynchronous active-high reset.
- in_valid, input, 1: in_data carries a pattern word this cycle.
- in_data, input, WIDTH: received LFSR word.
- clear_cnt, input, 1: synchronous clear of err_count.
- locked, output, 1: checker in LOCKED state.
- err_pulse, output, 1: one-cycle pulse per counted word error.
- err_count, output, CNT_W: saturating count of word errors while locked.
- lockup, output, 1: all-ones lockup word detected (only with LOCKUP_DET_EN; otherwise tied 0).

Behaviour:
- Reset is asynchronous, active-high; clock is clk. Reset values: locked=0, err_pulse=0, err_count=0, lockup=0; FSM=SEARCH; prev register=0; have_prev=0; run counters=0.
- Prediction: expected = {prev[WIDTH-2:0], ~(prev[TAP_A]^prev[TAP_B])}. match = (in_data == expected).
- All state updates occur only on cycles with in_valid=1. On in_valid=0 nothing changes except err_pulse, which returns to 0.
- SEARCH state:
  - have_prev=0: load prev<=in_data, set have_prev=1, no compare.
  - match: match_run++. When match_run reaches LOCK_CNT, go to LOCKED, clear miss_run, and assert locked from the next cycle.
  - mismatch: match_run<=0.
  - prev<=in_data on every valid word (re-seed).
  - No errors are counted in SEARCH.
- LOCKED state:
  - prev<=expected on every valid word (flywheel), so a single corrupted word costs exactly one error.
  - match: miss_run<=0.
  - mismatch: err_pulse=1 on the next cycle; err_count++ (saturates at all-ones, no wrap); miss_run++.
  - When miss_run reaches LOSS_CNT: go to SEARCH, locked=0 on the next cycle, have_prev<=0, match_run<=0. The error on that word is still counted.
- Latency: all outputs are registered, one cycle after the in_valid word.
- clear_cnt: err_count<=0. If clear_cnt and a counted error occur in the same cycle, clear wins (result 0, but err_pulse still fires). clear_cnt does not affect the FSM.
- Reset asserted mid-operation returns everything to reset values immediately, regardless of clk. The first word after reset is a seed only.

Optional Feature:
- Macro: PRBS_CHECKER_LOCKUP_DET_EN.
- Defined: lockup is registered and goes to 1 when a valid in_data equals all-ones. All-ones is the stuck state of the XNOR LFSR. lockup stays 1 until a valid non-all-ones word arrives or reset. While lockup=1, a word that matches is not counted toward match_run, so lock cannot be declared on a stuck stream.
- Not defined: lockup is constant 0, all-ones words are treated like any other word, and no lockup logic is synthesised.

Test Plan:
- Acquire lock: after reset, feed 0x00,0x01,0x03,0x06,0x0C with in_valid=1 -> locked=1 in the cycle after 0x0C; err_count=0.
- Single error with flywheel: locked, send 0x19 in place of 0x18, then 0x10,0x01 -> one err_pulse, err_count=1, locked stays 1, no second error.
- Loss of lock: locked, send 0x00 three times -> err_count=3; locked=0 after the third; next five correct words 0x03,0x06,0x0C,0x18,0x10 re-lock.
- Gaps and clear: insert in_valid=0 bubbles between lock words -> lock still declared after 4 matches. Assert clear_cnt together with an error -> err_count=0, err_pulse=1.
- Saturation and reset: CNT_W=2, force 5 errors -> err_count stays 3. Assert rst mid-LOCKED -> locked=0, err_count=0 without a clock edge.
- Lockup (macro defined): feed 0x1F repeatedly -> lockup=1, locked stays 0; then feed 0x00,0x01 -> lockup=0. Without the macro: lockup=0, and locked=1 after five 0x1F words.
